// File: rtl/gray_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_updown_counter_if
// Description : Control and result bundle for gray_updown_counter.
//               master : drives enable / up / load / load_gray and
//                        observes gray / bin / tc
//               slave  : the counter itself
//   enable    count enable
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load strobe
//   load_gray Gray-encoded value to load
//   gray      registered Gray-code count
//   bin       registered binary view of gray
//   tc        terminal-count / boundary flag (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
interface gray_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin;
  logic             tc;

  modport master (
    output enable, up, load, load_gray,
    input  gray, bin, tc
  );

  modport slave (
    input  enable, up, load, load_gray,
    output gray, bin, tc
  );
endinterface
`default_nettype wire

// File: rtl/gray_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_updown_counter
// Description : Parametrised up/down Gray-code counter with clock enable,
//               synchronous Gray-encoded parallel load, wrap or saturate
//               behaviour at the range ends, a registered binary view and a
//               terminal-count flag.
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   bus       gray_updown_counter_if.slave (enable, up, load, load_gray in;
//             gray, bin, tc out). Interface WIDTH must equal WIDTH here.
// Parameters  : WIDTH (>=2), SATURATE (0 wrap / 1 hold), RESET_VALUE (binary)
// Revision    : 1.0 - initial release
// ============================================================================
module gray_updown_counter #(
  parameter int WIDTH       = 3,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  gray_updown_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] c_all_ones   = '1;
  localparam logic [WIDTH-1:0] c_zero       = '0;
  localparam logic [WIDTH-1:0] c_reset_bin  = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_reset_gray = c_reset_bin ^ (c_reset_bin >> 1);
  localparam bit               c_saturate   = (SATURATE != 0);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_step_bin;
  logic [WIDTH-1:0] w_count_bin;
  logic             w_at_top;
  logic             w_at_bottom;
  logic             w_at_boundary;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above
  // it. Written as a reduction so no bit depends on another bit of the same
  // vector.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_g2b
      assign w_load_bin[i] = ^(bus.load_gray >> i);
    end
  endgenerate

  assign w_at_top      = (r_bin == c_all_ones);
  assign w_at_bottom   = (r_bin == c_zero);
  // Boundary in the direction of travel; used both for tc and saturation.
  assign w_at_boundary = (bus.up & w_at_top) | (~bus.up & w_at_bottom);

  // Modular step naturally gives wrap; saturate mode simply holds instead.
  assign w_step_bin  = bus.up ? (r_bin + 1'b1) : (r_bin - 1'b1);
  assign w_count_bin = (c_saturate && w_at_boundary) ? r_bin : w_step_bin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= c_reset_bin;
      r_gray <= c_reset_gray;
    end else if (bus.load) begin
      r_bin  <= w_load_bin;
      r_gray <= bus.load_gray;
    end else if (bus.enable) begin
      r_bin  <= w_count_bin;
      r_gray <= w_count_bin ^ (w_count_bin >> 1);
    end
  end

  assign bus.bin  = r_bin;
  assign bus.gray = r_gray;
  assign bus.tc   = bus.enable & ~bus.load & w_at_boundary;

endmodule
`default_nettype wire

// File: tb/tb_gray_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_updown_counter
// Description : Self-checking bench for gray_updown_counter. Four instances:
//               A  WIDTH=3 wrap, RESET_VALUE=0   (table-driven vectors)
//               B  WIDTH=4 saturate              (saturation sequence)
//               C  WIDTH=3 wrap, RESET_VALUE=2   (asynchronous reset)
//               D  WIDTH=8 wrap                  (random vs reference model)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_updown_counter;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_c;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  gray_updown_counter_if #(.WIDTH(3)) ifa ();
  gray_updown_counter_if #(.WIDTH(4)) ifb ();
  gray_updown_counter_if #(.WIDTH(3)) ifc ();
  gray_updown_counter_if #(.WIDTH(8)) ifd ();

  gray_updown_counter #(.WIDTH(3), .SATURATE(0), .RESET_VALUE(0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa));
  gray_updown_counter #(.WIDTH(4), .SATURATE(1), .RESET_VALUE(0)) dut_b (
    .clk(clk), .reset(rst_a), .bus(ifb));
  gray_updown_counter #(.WIDTH(3), .SATURATE(0), .RESET_VALUE(2)) dut_c (
    .clk(clk), .reset(rst_c), .bus(ifc));
  gray_updown_counter #(.WIDTH(8), .SATURATE(0), .RESET_VALUE(0)) dut_d (
    .clk(clk), .reset(rst_a), .bus(ifd));

  typedef struct {
    logic       en;
    logic       up;
    logic       ld;
    logic [2:0] lg;
    logic       tc;    // expected tc with these inputs, before the edge
    logic [2:0] gray;  // expected gray after the edge
    logic [2:0] bin;   // expected bin after the edge
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] g2b8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Apply inputs just after a rising edge, check tc, then check the state
  // produced by the next rising edge.
  task automatic step_b(input logic en, input logic up, input logic ld,
                        input logic [3:0] lg, input logic tc,
                        input logic [3:0] g, input logic [3:0] b, input string nm);
    ifb.enable = en; ifb.up = up; ifb.load = ld; ifb.load_gray = lg;
    #1 check({nm, "_tc"}, 32'(ifb.tc), 32'(tc));
    @(posedge clk); #1;
    check({nm, "_gray"}, 32'(ifb.gray), 32'(g));
    check({nm, "_bin"},  32'(ifb.bin),  32'(b));
  endtask

  initial begin
    logic [7:0] mb;
    logic [7:0] prev_g;
    logic       en, up, ld, exp_tc;
    logic [7:0] lg;

    ifa.enable = 0; ifa.up = 0; ifa.load = 0; ifa.load_gray = '0;
    ifb.enable = 0; ifb.up = 0; ifb.load = 0; ifb.load_gray = '0;
    ifc.enable = 0; ifc.up = 0; ifc.load = 0; ifc.load_gray = '0;
    ifd.enable = 0; ifd.up = 0; ifd.load = 0; ifd.load_gray = '0;
    rst_a = 1'b1;
    rst_c = 1'b1;

    // Up 8 steps from reset: full wrap through 100 -> 000
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b001, 3'd1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b011, 3'd2};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b010, 3'd3};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b110, 3'd4};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 3'd5};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b101, 3'd6};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b100, 3'd7};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 3'd0};
    // Down 3 steps from 000: wrap to all-ones
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 3'b100, 3'd7};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b101, 3'd6};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b111, 3'd5};
    // Load wins over enable/up, then two disabled cycles
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 3'b110, 3'd4};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b110, 3'd4};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b110, 3'd4};
    // Direction reversal with no dead cycle
    vecs[14] = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b111, 3'd5};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b110, 3'd4};
    // Load all-ones while tc would otherwise be computed, then wrap up
    vecs[16] = '{1'b1, 1'b1, 1'b1, 3'b100, 1'b0, 3'b100, 3'd7};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 3'b000, 3'd0};

    // Release resets away from the clock edge
    repeat (2) @(posedge clk);
    #3 rst_a = 1'b0; rst_c = 1'b0;
    @(posedge clk); #1;

    check("a_reset_gray", 32'(ifa.gray), 32'h0);
    check("a_reset_bin",  32'(ifa.bin),  32'h0);
    check("a_reset_tc",   32'(ifa.tc),   32'h0);
    check("c_reset_gray", 32'(ifc.gray), 32'h3);
    check("c_reset_bin",  32'(ifc.bin),  32'h2);

    // ---------------- A: table-driven ----------------
    for (int i = 0; i < 18; i++) begin
      ifa.enable = vecs[i].en; ifa.up = vecs[i].up;
      ifa.load = vecs[i].ld;   ifa.load_gray = vecs[i].lg;
      #1 check($sformatf("a_v%0d_tc", i), 32'(ifa.tc), 32'(vecs[i].tc));
      @(posedge clk); #1;
      check($sformatf("a_v%0d_gray", i), 32'(ifa.gray), 32'(vecs[i].gray));
      check($sformatf("a_v%0d_bin", i),  32'(ifa.bin),  32'(vecs[i].bin));
    end
    ifa.enable = 0; ifa.load = 0;

    // ---------------- B: saturation (WIDTH=4) ----------------
    step_b(1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 4'b1000, 4'd15, "b_load15");
    for (int k = 0; k < 3; k++)
      step_b(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b1000, 4'd15, $sformatf("b_sat_hi%0d", k));
    step_b(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1001, 4'd14, "b_down");
    step_b(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 4'd0,  "b_load0");
    step_b(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 4'd0,  "b_sat_lo");
    step_b(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0001, 4'd1,  "b_up_from0");
    ifb.enable = 0;

    // ---------------- C: asynchronous reset mid-count ----------------
    ifc.enable = 1; ifc.up = 1;
    repeat (3) @(posedge clk);
    #1 check("c_before_rst_bin", 32'(ifc.bin), 32'd5);
    #2 rst_c = 1'b1;
    #1 check("c_async_gray", 32'(ifc.gray), 32'h3);
    check("c_async_bin", 32'(ifc.bin), 32'd2);
    #1 rst_c = 1'b0;
    @(posedge clk); #1;
    check("c_resume_gray", 32'(ifc.gray), 32'h2);
    check("c_resume_bin",  32'(ifc.bin),  32'd3);
    ifc.enable = 0;

    // ---------------- D: random vs reference model (WIDTH=8) ----------------
    mb = 8'd0;
    check("d_start_bin", 32'(ifd.bin), 32'd0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 15) == 0);
      lg = 8'($urandom);
      ifd.enable = en; ifd.up = up; ifd.load = ld; ifd.load_gray = lg;
      exp_tc = en && !ld && ((up && mb == 8'hFF) || (!up && mb == 8'h00));
      prev_g = ifd.gray;
      #1 check("d_tc", 32'(ifd.tc), 32'(exp_tc));
      if (ld)      mb = g2b8(lg);
      else if (en) mb = up ? mb + 8'd1 : mb - 8'd1;
      @(posedge clk); #1;
      check("d_bin",  32'(ifd.bin),  32'(mb));
      check("d_gray", 32'(ifd.gray), 32'(mb ^ (mb >> 1)));
      check("d_views_agree", 32'(g2b8(ifd.gray)), 32'(ifd.bin));
      if (en && !ld)
        check("d_one_bit_step", 32'($countones(prev_g ^ ifd.gray)), 32'd1);
    end
    ifd.enable = 0; ifd.load = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
